// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the system-ID slave.
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and timestamp words and publishes sticky match status.
// Optional per-read stall timeout is enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1536932732,
  parameter bit          AUTO_START         = 1'b1
`ifdef SYSID_CHECK_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES   = 255
`endif
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  sysid_boot_checker_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        id_mismatch,
  output logic                        ts_mismatch,
  output logic                        timeout,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    RD_TS   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  // High only in the first cycle after reset release; masks a start seen on that edge.
  logic        first_q, first_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_mm_q, id_mm_d;
  logic        ts_mm_q, ts_mm_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;

  logic        rd_stall;
  logic        rd_accept;
  logic        tmo_hit;
  logic        run_start;

  assign rd_stall  = avm.avm_read &  avm.avm_waitrequest;
  assign rd_accept = avm.avm_read & ~avm.avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  // The stall that brings the count to TIMEOUT_CYCLES is the last one; read drops next cycle.
  assign tmo_hit = rd_stall & (wcnt_q == CNT_LAST);

  always_comb begin
    wcnt_d = '0;
    if (rd_stall) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (first_q ? AUTO_START : start) state_d = RD_ID;
      end
      RD_ID: begin
        if (rd_accept)    state_d = RD_TS;
        else if (tmo_hit) state_d = DONE;
      end
      RD_TS: begin
        if (rd_accept)    state_d = COMPARE;
        else if (tmo_hit) state_d = DONE;
      end
      COMPARE: state_d = DONE;
      DONE: begin
        if (start) state_d = RD_ID;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from the state flop so reset clears the bus at once.
  always_comb begin
    avm.avm_read    = 1'b0;
    avm.avm_address = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (state_q)
      RD_ID: begin
        avm.avm_read = 1'b1;
        busy         = 1'b1;
      end
      RD_TS: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = 1'b1;
        busy            = 1'b1;
      end
      COMPARE: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign run_start = (state_d == RD_ID) && (state_q != RD_ID);

  // Capture and status registers
  always_comb begin
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_mm_d    = id_mm_q;
    ts_mm_d    = ts_mm_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    if (run_start) begin
      id_value_d = '0;
      ts_value_d = '0;
      id_mm_d    = 1'b0;
      ts_mm_d    = 1'b0;
      pass_d     = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      if (state_q == RD_ID && rd_accept) id_value_d = avm.avm_readdata;
      if (state_q == RD_TS && rd_accept) ts_value_d = avm.avm_readdata;
      if (state_q == COMPARE) begin
        id_mm_d = (id_value_q != EXPECTED_ID);
        ts_mm_d = (ts_value_q != EXPECTED_TIMESTAMP);
        pass_d  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TIMESTAMP);
      end
      if (tmo_hit) begin
        timeout_d = 1'b1;
        pass_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value_q <= '0;
      ts_value_q <= '0;
      id_mm_q    <= 1'b0;
      ts_mm_q    <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_mm_q    <= id_mm_d;
      ts_mm_q    <= ts_mm_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
